// File: rtl/run_stuff_tx_if.sv
// Parallel-load / serial-out handshake bundle for run_stuff_tx.
// master drives the word request; slave is the transmitter itself.
interface run_stuff_tx_if #(
    parameter int WIDTH = 16,
    parameter int CNTW  = 4
);
    logic             START;
    logic [WIDTH-1:0] DATA;
    logic             STUFF_EN;
    logic             SER_OUT;
    logic             SER_VALID;
    logic             BUSY;
    logic             DONE;
    logic [CNTW-1:0]  STUFF_CNT;

    modport master (
        output START, DATA, STUFF_EN,
        input  SER_OUT, SER_VALID, BUSY, DONE, STUFF_CNT
    );

    modport slave (
        input  START, DATA, STUFF_EN,
        output SER_OUT, SER_VALID, BUSY, DONE, STUFF_CNT
    );
endinterface

// File: rtl/run_stuff_tx.sv
// Bit-serial MSB-first transmitter with optional bit stuffing: a complementary
// bit follows any three equal line bits, so the line never carries a run of four.
module run_stuff_tx #(
    parameter int WIDTH = 16,
    parameter int CNTW  = 4
) (
    input  logic           CLK,
    input  logic           RESET,
    run_stuff_tx_if.slave  bus
);
    localparam int REMW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SEND, STUFF, FIN} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_shreg;
    logic [REMW-1:0]  r_rem;
    logic             r_last;
    logic [1:0]       r_run;
    logic             r_sen;
    logic [CNTW-1:0]  r_stuff_cnt;

    logic             w_bit;
    logic [1:0]       w_run_nxt;
    logic [REMW-1:0]  w_rem_nxt;

    assign w_bit         = r_shreg[WIDTH-1];
    assign w_rem_nxt     = r_rem - REMW'(1);
    assign bus.STUFF_CNT = r_stuff_cnt;

    // Run length after the current data bit; saturates at 3 when stuffing is off.
    always_comb begin
        if (r_run == 2'd0 || w_bit != r_last)
            w_run_nxt = 2'd1;
        else if (r_run == 2'd3)
            w_run_nxt = 2'd3;
        else
            w_run_nxt = r_run + 2'd1;
    end

    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!RESET) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        w_next        = r_state;
        bus.SER_OUT   = 1'b0;
        bus.SER_VALID = 1'b0;
        bus.BUSY      = 1'b0;
        bus.DONE      = 1'b0;
        unique case (r_state)
            IDLE: if (bus.START) w_next = SEND;
            SEND: begin
                bus.SER_OUT   = w_bit;
                bus.SER_VALID = 1'b1;
                bus.BUSY      = 1'b1;
                if (r_sen && w_run_nxt == 2'd3) w_next = STUFF;
                else if (w_rem_nxt == '0)        w_next = FIN;
            end
            STUFF: begin
                bus.SER_OUT   = ~r_last;
                bus.SER_VALID = 1'b1;
                bus.BUSY      = 1'b1;
                w_next        = (r_rem != '0) ? SEND : FIN;
            end
            FIN: begin
                bus.DONE = 1'b1;
                w_next   = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: the datapath is reset too, so a frame aborted mid-flight leaves no residue.
        if (!RESET) begin
            r_shreg     <= '0;
            r_rem       <= '0;
            r_last      <= 1'b0;
            r_run       <= 2'd0;
            r_sen       <= 1'b0;
            r_stuff_cnt <= '0;
        end else begin
            unique case (r_state)
                IDLE: if (bus.START) begin
                    r_shreg     <= bus.DATA;
                    r_sen       <= bus.STUFF_EN;
                    r_rem       <= REMW'(WIDTH);
                    r_run       <= 2'd0;
                    r_stuff_cnt <= '0;
                end
                SEND: begin
                    r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
                    r_rem   <= w_rem_nxt;
                    r_run   <= w_run_nxt;
                    r_last  <= w_bit;
                end
                STUFF: begin
                    r_last      <= ~r_last;
                    r_run       <= 2'd1;
                    r_stuff_cnt <= r_stuff_cnt + CNTW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_run_stuff_tx.sv
// Self-checking bench for run_stuff_tx: queue-based frame model checked every
// cycle, plus literal frame contents and timings for directed words.
module tb_run_stuff_tx;
    logic CLK;
    logic RESET;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 0;

    run_stuff_tx_if #(.WIDTH(16), .CNTW(4)) bus ();

    run_stuff_tx #(.WIDTH(16), .CNTW(4)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a frame is the list of line bits derived from the stuffing rule.
    typedef struct packed {
        logic b;
        logic s;
    } ent_t;

    ent_t m_q[$];
    ent_t m_e;
    bit   m_fin = 0;
    int   m_cnt = 0;

    function automatic void build_frame(input logic [15:0] d, input logic sen);
        int   run;
        logic last;
        run  = 0;
        last = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (run == 0 || d[i] != last) run = 1;
            else                          run = run + 1;
            last = d[i];
            m_q.push_back('{b: d[i], s: 1'b0});
            if (sen && run == 3) begin
                m_q.push_back('{b: ~d[i], s: 1'b1});
                run  = 1;
                last = ~d[i];
            end
        end
    endfunction

    always @(posedge CLK) begin
        if (!RESET) begin
            m_q.delete();
            m_fin = 0;
            m_cnt = 0;
        end else if (m_fin) begin
            m_fin = 0;
        end else if (m_q.size() != 0) begin
            m_e = m_q.pop_front();
            if (m_e.s) m_cnt++;
            if (m_q.size() == 0) m_fin = 1;
        end else if (bus.START) begin
            build_frame(bus.DATA, bus.STUFF_EN);
            m_cnt = 0;
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            if (m_q.size() != 0) begin
                check("ser_out",   32'(bus.SER_OUT),   32'(m_q[0].b));
                check("ser_valid", 32'(bus.SER_VALID), 32'd1);
                check("busy",      32'(bus.BUSY),      32'd1);
                check("done",      32'(bus.DONE),      32'd0);
            end else begin
                check("ser_out",   32'(bus.SER_OUT),   32'd0);
                check("ser_valid", 32'(bus.SER_VALID), 32'd0);
                check("busy",      32'(bus.BUSY),      32'd0);
                check("done",      32'(bus.DONE),      32'(m_fin));
            end
            check("stuff_cnt", 32'(bus.STUFF_CNT), 32'(m_cnt));
        end
    end

    // Sends one word and checks the captured frame against literal values.
    task automatic send_frame(input string nm, input logic [15:0] d, input logic sen,
                              input logic [31:0] lit, input int len, input int exp_cnt,
                              input int exp_first4);
        logic [31:0] got;
        int   n, cyc, run, first4;
        bit   seen;
        logic last;
        @(negedge CLK);
        bus.START    = 1'b1;
        bus.DATA     = d;
        bus.STUFF_EN = sen;
        @(negedge CLK);
        bus.START    = 1'b0;
        bus.DATA     = ~d;
        bus.STUFF_EN = ~sen;
        got = '0; n = 0; seen = 0; cyc = 1;
        run = 0; last = 1'b0; first4 = -1;
        while (cyc <= 64) begin
            if (bus.SER_VALID) begin
                got = {got[30:0], bus.SER_OUT};
                if (run == 0 || bus.SER_OUT != last) run = 1;
                else                                 run++;
                last = bus.SER_OUT;
                if (run == 4 && first4 < 0) first4 = n;
                n++;
            end
            if (bus.DONE) begin
                seen = 1;
                break;
            end
            @(negedge CLK);
            cyc++;
        end
        check({nm, "_done_seen"}, 32'(seen), 32'd1);
        check({nm, "_done_cycle"}, 32'(cyc), 32'(len + 1));
        check({nm, "_nbits"}, 32'(n), 32'(len));
        check({nm, "_bits"}, got, lit);
        check({nm, "_stuff_cnt"}, 32'(bus.STUFF_CNT), 32'(exp_cnt));
        check({nm, "_first_run4"}, 32'(first4), 32'(exp_first4));
    endtask

    initial begin
        int done_t[$];
        RESET        = 1'b0;
        bus.START    = 1'b0;
        bus.DATA     = '0;
        bus.STUFF_EN = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("reset_outputs",
              {27'd0, bus.SER_OUT, bus.SER_VALID, bus.BUSY, bus.DONE, 1'b0} | 32'(bus.STUFF_CNT),
              32'd0);
        chk_en = 1;
        RESET  = 1'b1;

        send_frame("aaaa_s1", 16'hAAAA, 1'b1, 32'h0000AAAA, 16, 0, -1);
        send_frame("ffff_s0", 16'hFFFF, 1'b0, 32'h0000FFFF, 16, 0, 3);
        send_frame("ffff_s1", 16'hFFFF, 1'b1, 32'h001DDDDD, 21, 5, -1);
        send_frame("f0f0_s1", 16'hF0F0, 1'b1, 32'h000E8BA2, 20, 4, -1);

        // START held high: frames restart right after each DONE.
        @(negedge CLK);
        bus.START    = 1'b1;
        bus.DATA     = 16'h0001;
        bus.STUFF_EN = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge CLK);
            if (c == 8) bus.DATA = 16'hFFFF;
            if (bus.DONE) done_t.push_back(c);
        end
        bus.START = 1'b0;
        check("held_start_frames", 32'(done_t.size()), 32'd3);
        if (done_t.size() >= 2) check("held_start_period", 32'(done_t[1] - done_t[0]), 32'd18);
        else                    check("held_start_period", 32'd0, 32'd18);
        repeat (20) @(negedge CLK);

        // Reset asserted during the seventh line bit of a stuffed 16'hFFFF frame.
        bus.START    = 1'b1;
        bus.DATA     = 16'hFFFF;
        bus.STUFF_EN = 1'b1;
        @(negedge CLK);
        bus.START = 1'b0;
        repeat (6) @(negedge CLK);
        check("pre_reset_stuff_cnt", 32'(bus.STUFF_CNT), 32'd1);
        RESET = 1'b0;
        @(negedge CLK);
        check("midframe_reset_outputs",
              {27'd0, bus.SER_OUT, bus.SER_VALID, bus.BUSY, bus.DONE, 1'b0} | 32'(bus.STUFF_CNT),
              32'd0);
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        check("no_resume_busy", 32'(bus.BUSY), 32'd0);
        send_frame("after_reset", 16'hFFFF, 1'b1, 32'h001DDDDD, 21, 5, -1);

        repeat (3) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end
endmodule
